// File: rtl/pcie_tx_block_scheduler.sv
// Per-cycle block selector ahead of the PCIe Gen3 TX scrambler: payload/idle data, SKP and EIEOS.
// Build option: define PCIE_SKP_INSERT_EN to insert a SKP ordered set every SKP_INTERVAL data blocks.
module pcie_tx_block_scheduler #(
    parameter int DW           = 128,
    parameter int SKP_INTERVAL = 370
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] dl_data,
    input  logic          dl_valid,
    output logic          dl_ready,
    input  logic          os_req,
    output logic          os_ack,
    output logic [DW-1:0] scr_data,
    output logic          scr_valid,
    output logic          scr_is_ctl,
    output logic [1:0]    sync_hdr,
    output logic          lfsr_seed_load
);

    // Encoding doubles as the registered output bits:
    // [3]=scr_valid, [2]=lfsr_seed_load, [1:0]=sync_hdr (bit 0 also means control block).
    typedef enum logic [3:0] {
        ST_OFF   = 4'b0000,
        ST_DATA  = 4'b1010,
        ST_SKP   = 4'b1001,
        ST_EIEOS = 4'b1101
    } state_t;

    localparam logic [DW-1:0] SKP_BLK   = 128'h0000_00E1_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [DW-1:0] EIEOS_BLK = {8{16'hFF00}};

    if (DW != 128 || SKP_INTERVAL < 2 || SKP_INTERVAL > 4095) begin : g_bad_cfg
        $error("pcie_tx_block_scheduler: unsupported DW or SKP_INTERVAL");
    end

    state_t          state_q, state_d;
    logic [DW-1:0]   scr_data_q, scr_data_d;
    logic            skp_hold;

`ifdef PCIE_SKP_INSERT_EN
    localparam logic [11:0] CNT_LAST = 12'(SKP_INTERVAL - 1);

    logic [11:0] blk_cnt_q, blk_cnt_d;
    logic        skp_pending_q, skp_pending_d;

    assign skp_hold = skp_pending_q;
`else
    assign skp_hold = 1'b0;
`endif

    always_comb begin
        state_d = ST_OFF;
        if (!rst && enable) begin
            if (skp_hold)    state_d = ST_SKP;
            else if (os_req) state_d = ST_EIEOS;
            else             state_d = ST_DATA;
        end
    end

    assign dl_ready = (state_d == ST_DATA);
    assign os_ack   = (state_d == ST_EIEOS);

    always_comb begin
        scr_data_d = '0;
        case (state_d)
            ST_DATA:  scr_data_d = dl_valid ? dl_data : '0;
            ST_SKP:   scr_data_d = SKP_BLK;
            ST_EIEOS: scr_data_d = EIEOS_BLK;
            default:  scr_data_d = '0;
        endcase
    end

`ifdef PCIE_SKP_INSERT_EN
    // Idle blocks count toward the interval; ordered sets do not.
    always_comb begin
        blk_cnt_d     = blk_cnt_q;
        skp_pending_d = skp_pending_q;
        case (state_d)
            ST_DATA: begin
                if (blk_cnt_q == CNT_LAST) begin
                    blk_cnt_d     = '0;
                    skp_pending_d = 1'b1;
                end else begin
                    blk_cnt_d = blk_cnt_q + 12'd1;
                end
            end
            ST_SKP:  skp_pending_d = 1'b0;
            ST_OFF: begin
                blk_cnt_d     = '0;
                skp_pending_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q     <= '0;
            skp_pending_q <= 1'b0;
        end else begin
            blk_cnt_q     <= blk_cnt_d;
            skp_pending_q <= skp_pending_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            scr_data_q <= '0;
        end else begin
            state_q    <= state_d;
            scr_data_q <= scr_data_d;
        end
    end

    assign scr_data       = scr_data_q;
    assign scr_valid      = state_q[3];
    assign lfsr_seed_load = state_q[2];
    assign sync_hdr       = state_q[1:0];
    assign scr_is_ctl     = state_q[0];

endmodule

// File: tb/tb_pcie_tx_block_scheduler.sv
// Directed bench for pcie_tx_block_scheduler with SKP_INTERVAL=4; expectations follow PCIE_SKP_INSERT_EN.
module tb_pcie_tx_block_scheduler;

    localparam int DW = 128;

`ifdef PCIE_SKP_INSERT_EN
    localparam bit SKP_ON = 1'b1;
`else
    localparam bit SKP_ON = 1'b0;
`endif

    localparam logic [127:0] SKP_BLK   = 128'h0000_00E1_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [127:0] EIEOS_BLK = 128'hFF00_FF00_FF00_FF00_FF00_FF00_FF00_FF00;
    localparam logic [15:0]  M_SEQ     = SKP_ON ? 16'h0210 : 16'h0000;
    localparam logic [15:0]  M_FIFTH   = SKP_ON ? 16'h0010 : 16'h0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] dl_data;
    logic          dl_valid;
    logic          dl_ready;
    logic          os_req;
    logic          os_ack;
    logic [DW-1:0] scr_data;
    logic          scr_valid;
    logic          scr_is_ctl;
    logic [1:0]    sync_hdr;
    logic          lfsr_seed_load;

    int total = 0;
    int bad   = 0;
    int d     = 1;

    pcie_tx_block_scheduler #(.DW(DW), .SKP_INTERVAL(4)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .dl_data(dl_data), .dl_valid(dl_valid), .dl_ready(dl_ready),
        .os_req(os_req), .os_ack(os_ack),
        .scr_data(scr_data), .scr_valid(scr_valid), .scr_is_ctl(scr_is_ctl),
        .sync_hdr(sync_hdr), .lfsr_seed_load(lfsr_seed_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One selection per slot; mask bit i set means slot i must be a SKP.
    task automatic data_run(input string tag, input int n, input logic [15:0] skpm, input logic vld);
        for (int i = 0; i < n; i++) begin
            dl_valid = vld;
            dl_data  = 128'(d);
            #1;
            chk($sformatf("%s_rdy%0d", tag, i), 128'(dl_ready), 128'(!skpm[i]));
            tick();
            chk($sformatf("%s_vld%0d", tag, i), 128'(scr_valid), 128'(1'b1));
            chk($sformatf("%s_seed%0d", tag, i), 128'(lfsr_seed_load), 128'(1'b0));
            if (skpm[i]) begin
                chk($sformatf("%s_skp%0d", tag, i), scr_data, SKP_BLK);
                chk($sformatf("%s_shdr%0d", tag, i), 128'(sync_hdr), 128'(2'b01));
                chk($sformatf("%s_sctl%0d", tag, i), 128'(scr_is_ctl), 128'(1'b1));
            end else begin
                chk($sformatf("%s_dat%0d", tag, i), scr_data, vld ? 128'(d) : 128'h0);
                chk($sformatf("%s_dhdr%0d", tag, i), 128'(sync_hdr), 128'(2'b10));
                chk($sformatf("%s_dctl%0d", tag, i), 128'(scr_is_ctl), 128'(1'b0));
                if (vld) d++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; dl_valid = 1'b1; dl_data = 128'd1; os_req = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 128'(scr_valid), 128'(1'b0));
        chk("rst_ready", 128'(dl_ready), 128'(1'b0));
        chk("rst_ack", 128'(os_ack), 128'(1'b0));
        chk("rst_hdr", 128'(sync_hdr), 128'(2'b00));
        chk("rst_data", scr_data, 128'h0);
        chk("rst_ctl", 128'(scr_is_ctl), 128'(1'b0));
        chk("rst_seed", 128'(lfsr_seed_load), 128'(1'b0));
        rst = 1'b0; os_req = 1'b0;

        // Continuous payload 1,2,3,... with SKP after every 4th block
        data_run("seq", 10, M_SEQ, 1'b1);

        // Idle fill: zero blocks count toward the interval
        data_run("idle", 6, M_FIFTH, 1'b0);
        data_run("idle2", 3, 16'h0000, 1'b0);

        // Collision of pending SKP with an EIEOS request
        os_req = 1'b1;
        #1;
`ifdef PCIE_SKP_INSERT_EN
        chk("col_ack0", 128'(os_ack), 128'(1'b0));
        chk("col_rdy0", 128'(dl_ready), 128'(1'b0));
        tick();
        chk("col_skp", scr_data, SKP_BLK);
        chk("col_skp_seed", 128'(lfsr_seed_load), 128'(1'b0));
`endif
        chk("col_ack1", 128'(os_ack), 128'(1'b1));
        chk("col_rdy1", 128'(dl_ready), 128'(1'b0));
        tick();
        os_req = 1'b0;
        chk("eie_data", scr_data, EIEOS_BLK);
        chk("eie_lo16", 128'(scr_data[15:0]), 128'(16'hFF00));
        chk("eie_seed", 128'(lfsr_seed_load), 128'(1'b1));
        chk("eie_ctl", 128'(scr_is_ctl), 128'(1'b1));
        chk("eie_hdr", 128'(sync_hdr), 128'(2'b01));
        chk("eie_vld", 128'(scr_valid), 128'(1'b1));
        // Interval count must be untouched by the two ordered sets
        data_run("post_eie", 5, M_FIFTH, 1'b0);

        // Disable after 3 data blocks, then re-enable with a fresh count
        data_run("pre_dis", 3, 16'h0000, 1'b1);
        enable = 1'b0; os_req = 1'b1;
        #1;
        chk("dis_rdy", 128'(dl_ready), 128'(1'b0));
        chk("dis_ack", 128'(os_ack), 128'(1'b0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("dis_vld%0d", i), 128'(scr_valid), 128'(1'b0));
            chk($sformatf("dis_seed%0d", i), 128'(lfsr_seed_load), 128'(1'b0));
        end
        enable = 1'b1; os_req = 1'b0;
        data_run("reen", 5, M_FIFTH, 1'b1);

        // Reset while a SKP is pending: no SKP after release
        data_run("pre_rst", 4, 16'h0000, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_vld", 128'(scr_valid), 128'(1'b0));
        chk("mrst_rdy", 128'(dl_ready), 128'(1'b0));
        chk("mrst_hdr", 128'(sync_hdr), 128'(2'b00));
        chk("mrst_data", scr_data, 128'h0);
        tick();
        chk("mrst_hold", 128'(scr_valid), 128'(1'b0));
        rst = 1'b0;
        data_run("post_rst", 5, M_FIFTH, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcie_tx_block_scheduler.md
PCIE_TX_BLOCK_SCHEDULER -- requirements
Module: pcie_tx_block_scheduler

Interface
REQ-001 SHALL have parameter DW, default 128: block width; only 128 is supported.
REQ-002 SHALL have parameter SKP_INTERVAL, default 370: data blocks between SKP ordered sets; legal range 2..4095.
REQ-003 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: enable  in  1  link in L0 and transmitting.
REQ-006 SHALL have ports: dl_data  in  DW  payload block; dl_valid  in  1  payload present.
REQ-007 SHALL have ports: dl_ready  out  1  payload accepted this cycle when high with dl_valid.
REQ-008 SHALL have ports: os_req  in  1  EIEOS request, level; os_ack  out  1  EIEOS grant.
REQ-009 SHALL have ports: scr_data  out  DW, scr_valid  out  1, scr_is_ctl  out  1  drive the scrambler inputs.
REQ-010 SHALL have ports: sync_hdr  out  2  2'b10 for data blocks, 2'b01 for ordered sets.
REQ-011 SHALL have ports: lfsr_seed_load  out  1  scrambler reseed strobe.

Function
REQ-012 Outputs SHALL be registered; a block selected in cycle N SHALL appear on scr_* in cycle N+1.
REQ-013 Internal states SHALL be OFF, DATA, SKP, EIEOS; the state SHALL name the block type currently driven.
REQ-014 Selection priority per cycle with enable=1 SHALL be: skp_pending -> SKP; else os_req -> EIEOS; else DATA.
REQ-015 dl_ready SHALL be combinational: enable & ~skp_pending & ~os_req.
REQ-016 In DATA selection, the block SHALL carry dl_data if dl_valid, else an idle block of all zeros; both are data blocks.
REQ-017 Data blocks SHALL output scr_is_ctl=0 and sync_hdr=2'b10.
REQ-018 SKP block SHALL be bytes 0..11 = 8'hAA, byte 12 = 8'hE1, bytes 13..15 = 8'h00 (byte 0 = bits [7:0]), with scr_is_ctl=1 and sync_hdr=2'b01.
REQ-019 EIEOS block SHALL be even bytes 8'h00 and odd bytes 8'hFF, with scr_is_ctl=1 and sync_hdr=2'b01.
REQ-020 os_ack SHALL be combinational, high in the cycle EIEOS is selected; the requester drops os_req after os_ack, and a held os_req SHALL yield another EIEOS.
REQ-021 lfsr_seed_load SHALL be high exactly in the cycles an EIEOS block is driven on scr_*.
REQ-022 blk_cnt SHALL increment on every selected data block, including idle blocks.
REQ-023 When a data block is selected with blk_cnt == SKP_INTERVAL-1, blk_cnt SHALL become 0 and skp_pending SHALL set.
REQ-024 SKP selection SHALL clear skp_pending.
REQ-025 EIEOS and SKP blocks SHALL NOT change blk_cnt.
REQ-026 SKP pending together with os_req SHALL send SKP, then EIEOS next cycle if os_req is still high.
REQ-027 enable=0 SHALL select OFF: scr_valid=0 next cycle, blk_cnt<=0, skp_pending<=0, no os_ack, dl_ready=0.
REQ-028 Re-enabling SHALL resume with a DATA selection and a fresh interval count.
REQ-029 scr_valid SHALL be 1 in every cycle following a cycle with enable=1.

Reset
REQ-030 With rst high: state=OFF, scr_data=0, scr_valid=0, scr_is_ctl=0, sync_hdr=2'b00, lfsr_seed_load=0, blk_cnt=0, skp_pending=0.
REQ-031 dl_ready and os_ack SHALL be 0 while rst is high.
REQ-032 Reset asserted mid-stream SHALL discard any pending SKP and SHALL NOT emit a partial or extra block after release.

Configuration
REQ-033 Macro PCIE_SKP_INSERT_EN defined SHALL enable SKP insertion per REQ-022..026.
REQ-034 Without PCIE_SKP_INSERT_EN, blk_cnt and skp_pending SHALL be absent, SKP SHALL never be selected, and dl_ready SHALL be enable & ~os_req.

Verification (SKP_INTERVAL=4, PCIE_SKP_INSERT_EN defined unless noted)
REQ-035 Reset check: rst=1 with enable=1 and dl_valid=1 -> scr_valid=0, dl_ready=0, sync_hdr=2'b00; after release and one cycle, first block is a data block.
REQ-036 SKP insertion: dl_valid=1 continuously with data 1,2,3,... -> scr_data sequence 1,2,3,4,SKP,5,6,7,8,SKP; dl_ready=0 in each SKP selection cycle.
REQ-037 Idle fill: enable=1, dl_valid=0 for 6 cycles -> 4 zero blocks with sync_hdr=2'b10, then SKP (byte12=8'hE1), then zero.
REQ-038 Collision: os_req rises in the cycle skp_pending=1 -> SKP, then EIEOS (first 16 bits 16'hFF00) with lfsr_seed_load=1 and os_ack one cycle after SKP selection; blk_cnt unchanged.
REQ-039 Disable: enable drops after 3 data blocks, re-enable 5 cycles later -> scr_valid=0 while disabled; 4 more data blocks precede the next SKP.
REQ-040 Macro off: 10 data blocks -> no SKP on scr_*, scr_is_ctl=0 throughout.
